// File: rtl/sfp_mul_sched.sv
// Shared signed fixed-point multiplier with round-robin arbitration across N_REQ requesters.
// A tag follows each accepted operation through a fixed-latency pipeline so the result returns to its owner.
module sfp_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int IW      = 8,
  parameter int QW      = 16,
  parameter int MUL_LAT = 2,
  parameter int CLIP    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*(IW+QW)-1:0] req_x,
  input  logic [N_REQ*(IW+QW)-1:0] req_y,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [IW+QW-1:0]     rsp_data,
  output logic                 rsp_clip,
  output logic                 busy
);

  localparam int W  = IW + QW;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          accept;

  logic [W-1:0]  sel_x;
  logic [W-1:0]  sel_y;
  logic signed [2*W-1:0] x_ext;
  logic signed [2*W-1:0] y_ext;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;
  logic          ovf;
  logic [W-1:0]  res;

  logic [MUL_LAT-1:0] pipe_valid;
  logic [PW-1:0]      pipe_tag  [MUL_LAT];
  logic [W-1:0]       pipe_data [MUL_LAT];
  logic               pipe_clip [MUL_LAT];

  // Search ptr, ptr+1, ... modulo N_REQ for the first valid requester.
  always_comb begin
    logic [PW:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!grant_found && req_valid[idx[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[PW-1:0];
      end
    end
  end

  assign accept = grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_x = req_x[i*W +: W];
        sel_y = req_y[i*W +: W];
      end
    end
  end

  // After the arithmetic shift, bits [2W-1:W-1] must all match the kept sign bit or the result overflowed.
  always_comb begin
    x_ext   = {{W{sel_x[W-1]}}, sel_x};
    y_ext   = {{W{sel_y[W-1]}}, sel_y};
    prod    = x_ext * y_ext;
    shifted = prod >>> QW;
    ovf     = !((&shifted[2*W-1:W-1]) || !(|shifted[2*W-1:W-1]));
    res     = shifted[W-1:0];
    if (CLIP != 0 && ovf) begin
      res = shifted[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
    end
  end

  // Data stages only load behind a valid entry, so the output holds its last result between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_tag[i]  <= '0;
        pipe_data[i] <= '0;
        pipe_clip[i] <= 1'b0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= grant_idx;
      if (accept) begin
        pipe_data[0] <= res;
        pipe_clip[0] <= ovf;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_clip[i] <= pipe_clip[i-1];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pipe_valid[MUL_LAT-1]) rsp_valid[pipe_tag[MUL_LAT-1]] = 1'b1;
  end

  assign rsp_data = pipe_data[MUL_LAT-1];
  assign rsp_clip = pipe_clip[MUL_LAT-1];
  assign busy     = |pipe_valid;

endmodule

// File: tb/tb_sfp_mul_sched.sv
// Directed bench for sfp_mul_sched: one wrapping and one saturating instance share the same stimulus.
module tb_sfp_mul_sched;

  localparam int N  = 4;
  localparam int W  = 24;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;

  logic [N-1:0]   ready_w, ready_s;
  logic [N-1:0]   rspv_w, rspv_s;
  logic [W-1:0]   data_w, data_s;
  logic           clip_w, clip_s;
  logic           busy_w, busy_s;

  int errors = 0;
  int checks = 0;

  sfp_mul_sched #(.N_REQ(N), .IW(8), .QW(16), .MUL_LAT(2), .CLIP(0)) dut_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_w),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rspv_w), .rsp_data(data_w),
    .rsp_clip(clip_w), .busy(busy_w)
  );

  sfp_mul_sched #(.N_REQ(N), .IW(8), .QW(16), .MUL_LAT(2), .CLIP(1)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_s),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rspv_s), .rsp_data(data_s),
    .rsp_clip(clip_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input int idx,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    req_valid = v;
    req_x[idx*W +: W] = x;
    req_y[idx*W +: W] = y;
  endtask

  // One isolated request: ready in the same cycle, response two edges later on both instances.
  task automatic doOp(input int idx, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] exp_wrap, input logic [W-1:0] exp_sat,
                      input logic exp_clip);
    logic [N-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    @(negedge clk);
    applyStimulus(onehot, idx, x, y);
    #1;
    checkOutput("op_ready", 32'(ready_w), 32'(onehot));
    @(negedge clk);
    req_valid = '0;
    #1;
    checkOutput("op_rsp_early", 32'(rspv_w), 32'd0);
    checkOutput("op_busy", 32'(busy_w), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("op_rsp_valid", 32'(rspv_w), 32'(onehot));
    checkOutput("op_data_wrap", 32'(data_w), 32'(exp_wrap));
    checkOutput("op_clip_wrap", 32'(clip_w), 32'(exp_clip));
    checkOutput("op_data_sat", 32'(data_s), 32'(exp_sat));
    checkOutput("op_clip_sat", 32'(clip_s), 32'(exp_clip));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] sp_valid [8];
    logic [N-1:0] sp_ready [8];
    logic [N-1:0] exp_r;

    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;

    // Reset state, including ready held low while requests are pending under reset.
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    #1;
    checkOutput("rst_ready", 32'(ready_w), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rspv_w), 32'd0);
    checkOutput("rst_busy", 32'(busy_w), 32'd0);
    checkOutput("rst_data", 32'(data_w), 32'd0);
    checkOutput("rst_clip", 32'(clip_w), 32'd0);
    req_valid = '0;
    rst = 1'b0;

    // Arithmetic vectors: basic, sign, truncation, floor, and overflow both ways.
    doOp(1, 24'h018000, 24'h020000, 24'h030000, 24'h030000, 1'b0);
    doOp(2, 24'hFE8000, 24'h020000, 24'hFD0000, 24'hFD0000, 1'b0);
    doOp(0, 24'h000001, 24'h000001, 24'h000000, 24'h000000, 1'b0);
    doOp(3, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    doOp(1, 24'h640000, 24'h020000, 24'hC80000, 24'h7FFFFF, 1'b1);
    doOp(2, 24'h9C0000, 24'h020000, 24'h380000, 24'h800000, 1'b1);

    // Fairness from a fresh reset: all four requesters valid for 12 cycles.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus('0, i, 24'((i + 1) << 16), 24'h020000);
    for (int c = 0; c < 14; c++) begin
      if (c != 0) @(negedge clk);
      req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      exp_r = (c < 12) ? 4'(1 << (c % 4)) : 4'h0;
      checkOutput("rr_ready", 32'(ready_w), 32'(exp_r));
      exp_r = (c >= 2) ? 4'(1 << ((c - 2) % 4)) : 4'h0;
      checkOutput("rr_rsp_valid", 32'(rspv_w), 32'(exp_r));
      if (c >= 2) checkOutput("rr_data", 32'(data_w), 32'((((c - 2) % 4) + 1) * 2) << 16);
    end

    // Sparse contention: req 1 first moves ptr to 2, then only 1 and 3 compete.
    sp_valid = '{4'b0010, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
    sp_ready = '{4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = sp_valid[c];
      #1;
      checkOutput("sparse_ready", 32'(ready_w), 32'(sp_ready[c]));
    end

    // Reset with two operations in flight; ptr is 2 beforehand, so a regrant from 0 shows the reset.
    @(negedge clk);
    req_valid = 4'b0011;
    #1;
    checkOutput("mid_ready0", 32'(ready_w), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("mid_ready1", 32'(ready_w), 32'h2);
    checkOutput("mid_busy", 32'(busy_w), 32'd1);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checkOutput("mid_ready_rst", 32'(ready_w), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_busy_after", 32'(busy_w), 32'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("mid_no_rsp", 32'(rspv_w | rspv_s), 32'd0);
      @(negedge clk);
      #1;
    end
    req_valid = 4'hF;
    #1;
    checkOutput("mid_regrant", 32'(ready_w), 32'h1);
    @(negedge clk);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
